// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter
// Program-counter sequencer and port arbiter for a single-port, asynchronously
// read instruction memory shared between the CPU fetch path and a program loader.
// Optional feature macro: IMEM_BOUNDS_CHECK_EN (address/alignment fault check).
//
// state  | meaning
// -------+------------------------------------------------------------------
// S_LOAD | loader owns the port, no fetch; ld_done starts execution
// S_RUN  | fetching at pc; a loader write preempts the fetch for one cycle
// S_HALT | zero word fetched (or fault); pc frozen, loader may write/restart
module imem_fetch_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_ld_valid,
    output logic                       o_ld_ready,
    input  logic [$clog2(DEPTH)-1:0]   i_ld_addr,
    input  logic [DATA_W-1:0]          i_ld_data,
    input  logic                       i_ld_done,
    input  logic                       i_cpu_stall,
    input  logic                       i_br_taken,
    input  logic [ADDR_W-1:0]          i_br_target,
    output logic [$clog2(DEPTH)-1:0]   o_mem_addr,
    output logic                       o_mem_we,
    output logic [DATA_W-1:0]          o_mem_wdata,
    input  logic [DATA_W-1:0]          i_mem_rdata,
    output logic [ADDR_W-1:0]          o_pc,
    output logic [DATA_W-1:0]          o_instr,
    output logic                       o_instr_valid,
    output logic                       o_halted,
    output logic                       o_fault,
    output logic [15:0]                o_fetch_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [15:0]       r_fetch_cnt;
    logic [15:0]       w_fetch_cnt_nxt;
    logic              w_grant;
    logic              w_zero_word;
    logic [ADDR_W-1:0] w_seq_pc;
`ifdef IMEM_BOUNDS_CHECK_EN
    logic              r_fault;
    logic              w_fault_nxt;
    logic              w_bad_pc;
`endif

    // Fetch is granted only in RUN when the loader is not using the port.
    assign w_grant     = (r_state == S_RUN) && !i_ld_valid;
    assign w_zero_word = (i_mem_rdata == '0);
    assign w_seq_pc    = i_br_taken ? i_br_target : (r_pc + ADDR_W'(4));

`ifdef IMEM_BOUNDS_CHECK_EN
    assign w_bad_pc = ({1'b0, w_seq_pc} >= (ADDR_W + 1)'(DEPTH * 4)) ||
                      (i_br_taken && (i_br_target[1:0] != 2'b00));
    assign o_fault  = r_fault;
`else
    assign o_fault  = 1'b0;
`endif

    // Port mux: a pending loader write always takes the memory port.
    assign o_ld_ready    = !i_reset;
    assign o_mem_we      = !i_reset && i_ld_valid;
    assign o_mem_addr    = i_ld_valid ? i_ld_addr : r_pc[AW+1:2];
    assign o_mem_wdata   = i_ld_data;
    assign o_instr       = i_mem_rdata;
    assign o_instr_valid = !i_reset && w_grant && !w_zero_word;
    assign o_pc          = r_pc;
    assign o_halted      = (r_state == S_HALT);
    assign o_fetch_cnt   = r_fetch_cnt;

    // Next-state, next-pc and fetch counter decisions.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_fetch_cnt_nxt = r_fetch_cnt;
`ifdef IMEM_BOUNDS_CHECK_EN
        w_fault_nxt     = r_fault;
`endif
        case (r_state)
            S_LOAD, S_HALT: begin
                if (i_ld_done) begin
                    w_state_nxt     = S_RUN;
                    w_pc_nxt        = RESET_PC;
                    w_fetch_cnt_nxt = '0;
`ifdef IMEM_BOUNDS_CHECK_EN
                    w_fault_nxt     = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (w_grant) begin
                    if (w_zero_word) begin
                        w_state_nxt = S_HALT;
                    end else if (!i_cpu_stall) begin
                        if (r_fetch_cnt != 16'hFFFF) begin
                            w_fetch_cnt_nxt = r_fetch_cnt + 16'd1;
                        end
`ifdef IMEM_BOUNDS_CHECK_EN
                        if (w_bad_pc) begin
                            w_state_nxt = S_HALT;
                            w_fault_nxt = 1'b1;
                        end else begin
                            w_pc_nxt = w_seq_pc;
                        end
`else
                        w_pc_nxt = w_seq_pc;
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // State, pc and counter registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_LOAD;
            r_pc        <= RESET_PC;
            r_fetch_cnt <= '0;
`ifdef IMEM_BOUNDS_CHECK_EN
            r_fault     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_fetch_cnt <= w_fetch_cnt_nxt;
`ifdef IMEM_BOUNDS_CHECK_EN
            r_fault     <= w_fault_nxt;
`endif
        end
    end

endmodule

// File: doc/imem_fetch_arbiter.md
# imem_fetch_arbiter

Sequencer and port arbiter for the single-port, asynchronously read instruction memory of the single-cycle RISC-V core. Owns the program counter, drives the memory word address each cycle, and shares the memory port between the CPU fetch path and a program loader that writes instruction words. Sits between the instruction memory and the core's decode stage; the core supplies stall and branch-redirect inputs.

## Interface
- `ADDR_W`, 32: PC / byte-address width
- `DATA_W`, 32: instruction word width
- `DEPTH`, 32: memory depth in words, power of two
- `RESET_PC`, 0: byte address fetched first after load completes
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `ld_valid`  in  1  loader write request
- `ld_ready`  out  1  loader write accepted this cycle
- `ld_addr`  in  `$clog2(DEPTH)`  loader word index
- `ld_data`  in  DATA_W  loader write data
- `ld_done`  in  1  loader finished; one-cycle pulse
- `cpu_stall`  in  1  hold PC, no new fetch consumed
- `br_taken`  in  1  redirect PC to `br_target`
- `br_target`  in  ADDR_W  redirect byte address
- `mem_addr`  out  `$clog2(DEPTH)`  word index to instruction memory
- `mem_we`  out  1  memory write enable
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory async read data
- `pc`  out  ADDR_W  address of `instr`
- `instr`  out  DATA_W  fetched instruction
- `instr_valid`  out  1  `instr` is valid for decode this cycle
- `halted`  out  1  sequencer in HALT
- `fault`  out  1  sticky address fault
- `fetch_cnt`  out  16  instructions consumed since last RUN entry, saturating

## Operation
- States: LOAD, RUN, HALT. Reset enters LOAD.
- LOAD: `ld_ready`=1; `ld_valid` -> `mem_we`=1, `mem_addr`=`ld_addr`, `mem_wdata`=`ld_data`. `instr_valid`=0. `ld_done` -> RUN, `pc`<=RESET_PC, `fetch_cnt`<=0, `fault`<=0.
- RUN: `mem_addr`=`pc[log2(DEPTH)+1:2]`, `instr`=`mem_rdata`, `instr_valid`=1 unless loader owns port.
- Arbitration in RUN: `ld_valid` has priority. That cycle: write performed, `ld_ready`=1, `instr_valid`=0, PC held, `fetch_cnt` unchanged. `ld_done` in RUN is ignored.
- PC update in RUN when fetch granted: `cpu_stall` -> hold; else `br_taken` -> `br_target`; else `pc+4`, mod 2^ADDR_W. Stall beats branch.
- Consumed fetch (granted, not stalled) increments `fetch_cnt`, saturating at 0xFFFF.
- Halt trigger: granted fetch with `mem_rdata`==0 -> HALT next edge; the zero word is presented with `instr_valid`=0.
- HALT: `halted`=1, `instr_valid`=0, PC frozen; `ld_ready`=1, loader writes allowed; `ld_done` -> RUN as from LOAD.
- `ld_valid` and `ld_done` in the same LOAD/HALT cycle: write performed, then transition.

## Timing
- Reset values: `pc`=RESET_PC, `instr_valid`=0, `halted`=0, `fault`=0, `fetch_cnt`=0, `mem_we`=0, `ld_ready`=0 during reset cycle, state LOAD.
- Read path combinational: `instr` follows `pc` in the same cycle, zero latency.
- Write completes at the edge where `mem_we`=1. Read-after-write of the same word is visible on the next cycle.
- `ld_ready` is combinational from state; loader handshake completes in one cycle when `ld_valid`&&`ld_ready`.
- First RUN fetch occurs the cycle after `ld_done`.
- `reset` mid-RUN or mid-load: return to LOAD next edge. Memory contents untouched.

## Configuration
- `IMEM_BOUNDS_CHECK_EN` defined: next PC with `pc>=DEPTH*4` or `br_target[1:0]!=0` -> HALT, `fault`<=1, offending PC not fetched.
- Undefined: no check, `fault` tied 0, address wraps modulo DEPTH words, `br_target[1:0]` ignored.

## Test plan
- Load words 0x00100093, 0x00100113, 0x00000000 at indices 0..2, pulse `ld_done` -> `pc` 0,4,8 on consecutive cycles; HALT entered after pc=8, `fetch_cnt`=2.
- RUN at pc=4 with `cpu_stall`=1 for 3 cycles and `br_taken`=1 -> `pc` stays 4, `fetch_cnt` unchanged; release stall with `br_taken`=1, target 0x10 -> next `pc`=0x10.
- `ld_valid` at index 5 during RUN at pc=8 -> `instr_valid`=0 that cycle, `mem_we`=1, `mem_addr`=5; next cycle `pc` still 8, `instr_valid`=1.
- Branch target 0x7E (bounds macro on) -> HALT, `fault`=1; macro off -> fetch at word index 31, `fault`=0.
- Assert `reset` mid-RUN at pc=0x0C -> next cycle state LOAD, `pc`=0, `instr_valid`=0, previously loaded words read back unchanged after `ld_done`.
